// File: rtl/pte_cache_pkg.sv
// Shared types and address-split helpers for the PTE cache.
package pte_cache_pkg;

    localparam int unsigned STAT_W = 16;

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } state_e;

    // Helpers work on a 64-bit view; callers truncate to their own widths.
    function automatic logic [63:0] line_index(input logic [63:0] addr, input int unsigned idx_w);
        return (addr >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] line_tag(input logic [63:0] addr, input int unsigned idx_w);
        return addr >> (2 + idx_w);
    endfunction

endpackage

// File: rtl/pte_cache_array.sv
// Valid/tag/data storage for the PTE cache: combinational read, one write port, flush-all.
module pte_cache_array #(
    parameter int unsigned LINES      = 16,
    parameter int unsigned TAG_W      = 26,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W     = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush
);

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    // Flush beats a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/pte_cache.sv
// Direct-mapped read-only PTE cache between the page-table walker and memory.
// Optional PTE_CACHE_STATS_EN adds saturating hit/miss counters.
module pte_cache
    import pte_cache_pkg::*;
#(
    parameter int unsigned LINES      = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ptw_mem_req,
    input  logic [ADDR_WIDTH-1:0] ptw_mem_addr,
    output logic                  ptw_mem_resp,
    output logic [DATA_WIDTH-1:0] ptw_mem_data,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  sfence_all,
    output logic                  cache_hit,
    output logic                  busy,
    output logic [STAT_W-1:0]     hit_count,
    output logic [STAT_W-1:0]     miss_count
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_WIDTH - 2 - IDX_W;

    state_e                state_q, state_d;
    logic                  resp_q, resp_d;
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  drop_q, drop_d;

    logic [IDX_W-1:0]      lookup_idx, fill_idx;
    logic [TAG_W-1:0]      lookup_tag, fill_tag;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  accept, lookup_hit, fill_we;

    assign lookup_idx = IDX_W'(line_index(64'(ptw_mem_addr), IDX_W));
    assign lookup_tag = TAG_W'(line_tag(64'(ptw_mem_addr), IDX_W));
    assign fill_idx   = IDX_W'(line_index(64'(mem_addr_q), IDX_W));
    assign fill_tag   = TAG_W'(line_tag(64'(mem_addr_q), IDX_W));

    // A flush on the lookup edge forces a miss.
    assign lookup_hit = rd_valid && (rd_tag == lookup_tag) && !sfence_all;
    assign accept     = (state_q == StIdle) && ptw_mem_req && !resp_q;
    assign fill_we    = (state_q == StFill) && mem_ack && !drop_q && !sfence_all;

    pte_cache_array #(
        .LINES      (LINES),
        .TAG_W      (TAG_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lookup_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_we),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_data  (mem_rdata),
        .flush    (sfence_all)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && !lookup_hit) state_d = StFill;
            StFill: if (mem_ack) state_d = StIdle;
        endcase
    end

    always_comb begin
        resp_d     = 1'b0;
        hit_d      = 1'b0;
        data_d     = data_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        drop_d     = drop_q;
        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (accept) begin
                    if (lookup_hit) begin
                        resp_d = 1'b1;
                        hit_d  = 1'b1;
                        data_d = rd_data;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {ptw_mem_addr[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
            end
            StFill: begin
                if (mem_ack) begin
                    resp_d    = 1'b1;
                    data_d    = mem_rdata;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                end else if (sfence_all) begin
                    drop_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q     <= 1'b0;
            hit_q      <= 1'b0;
            data_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            resp_q     <= resp_d;
            hit_q      <= hit_d;
            data_q     <= data_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            drop_q     <= drop_d;
        end
    end

    assign ptw_mem_resp = resp_q;
    assign ptw_mem_data = data_q;
    assign cache_hit    = hit_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign busy         = (state_q == StFill);

`ifdef PTE_CACHE_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept) begin
            if (lookup_hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_pte_cache.sv
// Directed plus randomized bench for pte_cache against a line-occupancy reference model.
module tb_pte_cache;

    logic        clk;
    logic        rst;
    logic        ptw_mem_req;
    logic [31:0] ptw_mem_addr;
    logic        ptw_mem_resp;
    logic [31:0] ptw_mem_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        sfence_all;
    logic        cache_hit;
    logic        busy;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int ntests = 0;
    int nfail  = 0;

    // Model: which word address each of the 16 lines currently holds.
    bit          m_valid [16];
    logic [31:0] m_word  [16];
    logic [31:0] m_data  [16];
    int          exp_hits   = 0;
    int          exp_misses = 0;
    logic [31:0] last_data  = 32'h0;

    pte_cache dut (
        .clk          (clk),
        .rst          (rst),
        .ptw_mem_req  (ptw_mem_req),
        .ptw_mem_addr (ptw_mem_addr),
        .ptw_mem_resp (ptw_mem_resp),
        .ptw_mem_data (ptw_mem_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .sfence_all   (sfence_all),
        .cache_hit    (cache_hit),
        .busy         (busy),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef PTE_CACHE_STATS_EN
        check({tag, "_hits"}, {16'h0, hit_count}, (exp_hits > 65535) ? 32'hFFFF : exp_hits);
        check({tag, "_misses"}, {16'h0, miss_count},
              (exp_misses > 65535) ? 32'hFFFF : exp_misses);
`else
        check({tag, "_hits"}, {16'h0, hit_count}, 32'h0);
        check({tag, "_misses"}, {16'h0, miss_count}, 32'h0);
`endif
    endtask

    // One full PTW transaction. lat = idle cycles before ack; flush_acc on the lookup edge,
    // flush_mid on the first FILL edge (needs lat>0), flush_ack on the ack edge.
    task automatic request(input logic [31:0] addr, input logic [31:0] rdata, input int lat,
                           input bit flush_acc, input bit flush_mid, input bit flush_ack);
        int          idx;
        logic [31:0] wa;
        bit          exp_hit;
        bit          dropped;
        idx = int'(addr[5:2]);
        wa  = {addr[31:2], 2'b00};
        @(negedge clk);
        ptw_mem_req  = 1'b1;
        ptw_mem_addr = addr;
        sfence_all   = flush_acc;
        if (flush_acc) model_flush();
        exp_hit = m_valid[idx] && (m_word[idx] == wa);
        @(negedge clk);
        sfence_all = 1'b0;
        if (exp_hit) begin
            exp_hits++;
            check("hit_resp", {31'h0, ptw_mem_resp}, 32'h1);
            check("hit_flag", {31'h0, cache_hit}, 32'h1);
            check("hit_data", ptw_mem_data, m_data[idx]);
            check("hit_no_memreq", {31'h0, mem_req}, 32'h0);
            last_data   = m_data[idx];
            ptw_mem_req = 1'b0;
        end else begin
            exp_misses++;
            check("miss_noresp", {31'h0, ptw_mem_resp}, 32'h0);
            check("miss_memreq", {31'h0, mem_req}, 32'h1);
            check("miss_addr", mem_addr, wa);
            check("miss_busy", {31'h0, busy}, 32'h1);
            dropped = flush_ack || (flush_mid && lat > 0);
            for (int i = 0; i < lat; i++) begin
                if (flush_mid && i == 0) sfence_all = 1'b1;
                ptw_mem_addr = $urandom;
                @(negedge clk);
                sfence_all = 1'b0;
                check("fill_memreq_held", {31'h0, mem_req}, 32'h1);
                check("fill_addr_held", mem_addr, wa);
            end
            mem_ack    = 1'b1;
            mem_rdata  = rdata;
            sfence_all = flush_ack;
            @(negedge clk);
            mem_ack     = 1'b0;
            sfence_all  = 1'b0;
            ptw_mem_req = 1'b0;
            check("fill_resp", {31'h0, ptw_mem_resp}, 32'h1);
            check("fill_data", ptw_mem_data, rdata);
            check("fill_hitflag", {31'h0, cache_hit}, 32'h0);
            check("fill_memreq_drop", {31'h0, mem_req}, 32'h0);
            check("fill_busy_drop", {31'h0, busy}, 32'h0);
            last_data = rdata;
            if (dropped) model_flush();
            else begin
                m_valid[idx] = 1'b1;
                m_word[idx]  = wa;
                m_data[idx]  = rdata;
            end
        end
        @(negedge clk);
        check("resp_one_cycle", {31'h0, ptw_mem_resp}, 32'h0);
        check("data_held", ptw_mem_data, last_data);
    endtask

    task automatic pulse_sfence();
        @(negedge clk);
        sfence_all = 1'b1;
        @(negedge clk);
        sfence_all = 1'b0;
        model_flush();
    endtask

    initial begin
        logic [31:0] a;
        rst          = 1'b1;
        ptw_mem_req  = 1'b0;
        ptw_mem_addr = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
        sfence_all   = 1'b0;
        model_flush();
        repeat (2) @(negedge clk);
        check("rst_resp", {31'h0, ptw_mem_resp}, 32'h0);
        check("rst_data", ptw_mem_data, 32'h0);
        check("rst_memreq", {31'h0, mem_req}, 32'h0);
        check("rst_memaddr", mem_addr, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;

        // Miss then hit
        request(32'h8000_0000, 32'h2000_0401, 3, 0, 0, 0);
        request(32'h8000_0000, 32'hDEAD_BEEF, 0, 0, 0, 0);
        // Conflict eviction on index 0
        request(32'h8000_1000, 32'h1111_0001, 1, 0, 0, 0);
        request(32'h8000_0000, 32'h2000_0401, 2, 0, 0, 0);
        // Flush while idle
        request(32'h8000_0004, 32'h3333_0007, 1, 0, 0, 0);
        pulse_sfence();
        request(32'h8000_0004, 32'h3333_0007, 1, 0, 0, 0);
        // Flush on ack edge, then flush mid-FILL
        request(32'h8000_0010, 32'h0000_047F, 2, 0, 0, 1);
        request(32'h8000_0010, 32'h0000_047F, 0, 0, 0, 0);
        request(32'h8000_0014, 32'h0000_0555, 3, 0, 1, 0);
        request(32'h8000_0014, 32'h0000_0555, 1, 0, 0, 0);
        // Flush coincident with lookup
        request(32'h8000_0020, 32'h0000_0999, 1, 0, 0, 0);
        request(32'h8000_0020, 32'h0000_0999, 1, 1, 0, 0);
        check_stats("stats_directed");

        // Stray ack while idle is ignored
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_resp", {31'h0, ptw_mem_resp}, 32'h0);
        check("stray_ack_busy", {31'h0, busy}, 32'h0);

        // Reset mid-FILL drops mem_req immediately; 0x80000020 is cached beforehand
        @(negedge clk);
        ptw_mem_req  = 1'b1;
        ptw_mem_addr = 32'h8000_0030;
        @(negedge clk);
        check("rf_memreq", {31'h0, mem_req}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rf_memreq_drop", {31'h0, mem_req}, 32'h0);
        check("rf_busy", {31'h0, busy}, 32'h0);
        check("rf_resp", {31'h0, ptw_mem_resp}, 32'h0);
        check("rf_data", ptw_mem_data, 32'h0);
        check("rf_memaddr", mem_addr, 32'h0);
        ptw_mem_req = 1'b0;
        model_flush();
        exp_hits   = 0;
        exp_misses = 0;
        last_data  = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        check_stats("stats_after_rst");
        request(32'h8000_0020, 32'h0000_0ABC, 1, 0, 0, 0);

        // Randomized traffic over three tags so hits, conflicts and flushes mix
        for (int n = 0; n < 60; n++) begin
            a = 32'h8000_0000 + ($urandom_range(0, 2) << 12) + ($urandom_range(0, 15) << 2)
                + $urandom_range(0, 3);
            request(a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end
        check_stats("stats_random");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/pte_cache.md
# pte_cache

Small direct-mapped, read-only cache of page-table entries between the MMU's page-table-walker memory port (ptw_mem_req/addr/resp/data) and the system memory bus. It is downstream of the MMU. It serves repeated PTE fetches, such as upper-level PTEs shared across pages, in one cycle. Misses go to memory through a req/ack handshake, and the returned PTE is installed. SFENCE-all flushes every entry so the cache stays coherent with page-table updates.

## Interface
Parameters:
- LINES, 16, number of PTE entries; power of two, ≥2
- ADDR_WIDTH, 32, physical address width
- DATA_WIDTH, 32, PTE width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ptw_mem_req  in  1  PTE read request from MMU; held until ptw_mem_resp
- ptw_mem_addr  in  ADDR_WIDTH  PTE byte address; bits [1:0] ignored
- ptw_mem_resp  out  1  one-cycle response pulse
- ptw_mem_data  out  DATA_WIDTH  PTE; valid while ptw_mem_resp=1
- mem_req  out  1  memory read request; held until mem_ack
- mem_addr  out  ADDR_WIDTH  word-aligned miss address ([1:0]=0)
- mem_ack  in  1  memory read complete; mem_rdata valid same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- sfence_all  in  1  flush all entries
- cache_hit  out  1  pulse coincident with ptw_mem_resp when the response was a hit
- busy  out  1  high in FILL state

## Operation
- Address split: IDX_W=log2(LINES); index=addr[2+:IDX_W]; tag=addr[ADDR_WIDTH-1:2+IDX_W]. Each line holds valid, tag and data.
- FSM states are IDLE and FILL.
- **Acceptance.** In IDLE, a request is accepted on an edge where ptw_mem_req=1 and ptw_mem_resp=0. The requester must drop req in its resp cycle, so back-to-back requests are at least 2 cycles apart.
- **Hit.** Lookup is combinational on ptw_mem_addr in IDLE. On a hit at the acceptance edge: register resp=1, data=line data and cache_hit=1. The FSM stays in IDLE.
- **Miss.** On a miss: latch the word-aligned address, set mem_req=1 and mem_addr, and go to FILL.
- **FILL.** mem_addr and mem_req are held stable. On the edge where mem_ack=1:
  - install the line (valid=1, tag, mem_rdata)
  - set resp=1, data=mem_rdata, cache_hit=0
  - set mem_req=0 and return to IDLE
- ptw_mem_req changes during FILL are ignored. mem_ack outside FILL is ignored.
- **Flush.** sfence_all=1 at an edge clears all valid bits.
  - Simultaneous with a lookup in IDLE: flush wins, and the request is processed as a miss.
  - Asserted at any edge during FILL, including the ack edge: the response is still delivered, but the line is not installed. A drop flag is set and is cleared on return to IDLE.
- The cache is never written by the requester; A/D-bit updates bypass it.

## Timing
- **Reset values:** ptw_mem_resp=0, ptw_mem_data=0, mem_req=0, mem_addr=0, cache_hit=0, busy=0, all valid=0, state=IDLE. Reset takes effect immediately and asynchronously, including mid-FILL; mem_req drops without waiting for mem_ack.
- **Hit latency:** resp is high in the cycle after the acceptance edge (1 cycle).
- **Miss latency:**
  - mem_req rises in the cycle after the acceptance edge.
  - resp is high in the cycle after the mem_ack edge.
  - Total is 2 cycles plus the memory latency.
- ptw_mem_resp, cache_hit and ptw_mem_data are all registered. resp and cache_hit last exactly one cycle. ptw_mem_data holds its value until the next response.
- busy equals (state==FILL).

## Configuration
- PTE_CACHE_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each hit response; miss_count increments on each miss acceptance.
  - Both saturate at 0xFFFF and are cleared by rst. sfence_all does not clear them.
- Undefined: both ports are still present and tied to 0. No counter logic is generated.

## Structure
- Package pte_cache_pkg holds: the state enum (IDLE, FILL); functions for index and tag extraction; localparam STAT_W=16.
- Sub-module pte_cache_array holds the valid/tag/data storage. It provides a combinational read port, a single write port, and a flush-all input.
- Top pte_cache holds the FSM, the request/memory handshake, the drop flag and the optional counters.

## Test plan
1. **Reset.** Assert rst mid-simulation → all outputs 0, busy=0.
2. **Miss then hit.**
   - Request 0x80000000; memory acks 3 cycles after mem_req with 0x20000401 → mem_addr=0x80000000; resp carries 0x20000401 with cache_hit=0.
   - Re-request 0x80000000 → resp 1 cycle later with cache_hit=1 and no mem_req.
3. **Conflict eviction** (LINES=16).
   - 0x80000000, then 0x80001000: same index 0, second is a miss.
   - Then 0x80000000 again → miss with mem_req.
4. **Flush.** Fill 0x80000004, pulse sfence_all, re-request → miss with mem_req=1, mem_addr=0x80000004.
5. **Flush during FILL.** sfence_all asserted on the mem_ack edge with 0x0000047F → resp delivers 0x0000047F; the next request to the same address misses.
6. **Reset mid-FILL.** Assert rst while mem_req=1 → mem_req=0 immediately; after release, a request to the previously cached address misses.
